// File: rtl/dc1_xbit_wrsched_pkg.sv
// Shared types for the dc1 extra-bit write scheduler: update payload,
// insert FSM states and row-key/bank-span helpers used by conflict detection.
package dc1_pkg;

    localparam int XB_ROW_W  = 5;
    localparam int XB_ADDR_W = XB_ROW_W + 5;

    typedef struct packed {
        logic [XB_ADDR_W-1:0] addrE;
        logic [XB_ADDR_W-1:0] addrO;
        logic                 odd;
        logic [1:0]           pbit;
        logic                 d128;
    } xbit_upd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } ins_state_t;

    // Row key: target bank parity plus the row bits of that bank's address.
    function automatic logic [XB_ROW_W:0] rowKey(input xbit_upd_t u);
        logic [XB_ADDR_W-1:0] a;
        a = u.odd ? u.addrO : u.addrE;
        return {u.odd, a[XB_ROW_W+3:4]};
    endfunction

    // A 128-bit update at the last bit slot of a row also touches the opposite bank.
    function automatic logic spansBank(input xbit_upd_t u);
        logic [XB_ADDR_W-1:0] a;
        a = u.odd ? u.addrO : u.addrE;
        return u.d128 && (a[3:0] == 4'hf);
    endfunction

endpackage

// File: rtl/dc1_xbit_wrsched_if.sv
// Bus between the store/fill pipelines (master) and the write scheduler (slave).
// With DC1_XBIT_SCHED_STATS_EN defined the statistics counters are carried too.
interface dc1_xbit_wrsched_if #(parameter int ADDR_WIDTH = 5);

    localparam int AW = ADDR_WIDTH + 5;

    logic          upd0_valid, upd0_ready, upd0_odd, upd0_d128;
    logic [AW-1:0] upd0_addrE, upd0_addrO;
    logic [1:0]    upd0_pbit;
    logic          upd1_valid, upd1_ready, upd1_odd, upd1_d128;
    logic [AW-1:0] upd1_addrE, upd1_addrO;
    logic [1:0]    upd1_pbit;
    logic          ins_valid, ins_ready;
    logic [AW-1:0] ins_addrE, ins_addrO;
    logic [1:0]    ins_bank;
    logic [15:0]   ins_data;
    logic          write0_clkEn, write0_odd, write0_d128;
    logic [AW-1:0] write0_addrE, write0_addrO;
    logic [1:0]    write0_pbit;
    logic          write1_clkEn, write1_odd, write1_d128;
    logic [AW-1:0] write1_addrE, write1_addrO;
    logic [1:0]    write1_pbit;
    logic [1:0]    write_ins;
    logic [15:0]   write_data;
    logic          busy;
`ifdef DC1_XBIT_SCHED_STATS_EN
    logic [15:0]   stat_conflict, stat_ins;
`endif

    modport master (
        output upd0_valid, upd0_addrE, upd0_addrO, upd0_odd, upd0_pbit, upd0_d128,
        output upd1_valid, upd1_addrE, upd1_addrO, upd1_odd, upd1_pbit, upd1_d128,
        output ins_valid, ins_addrE, ins_addrO, ins_bank, ins_data,
        input  upd0_ready, upd1_ready, ins_ready,
        input  write0_clkEn, write0_addrE, write0_addrO, write0_odd, write0_pbit, write0_d128,
        input  write1_clkEn, write1_addrE, write1_addrO, write1_odd, write1_pbit, write1_d128,
        input  write_ins, write_data, busy
`ifdef DC1_XBIT_SCHED_STATS_EN
        , input stat_conflict, stat_ins
`endif
    );

    modport slave (
        input  upd0_valid, upd0_addrE, upd0_addrO, upd0_odd, upd0_pbit, upd0_d128,
        input  upd1_valid, upd1_addrE, upd1_addrO, upd1_odd, upd1_pbit, upd1_d128,
        input  ins_valid, ins_addrE, ins_addrO, ins_bank, ins_data,
        output upd0_ready, upd1_ready, ins_ready,
        output write0_clkEn, write0_addrE, write0_addrO, write0_odd, write0_pbit, write0_d128,
        output write1_clkEn, write1_addrE, write1_addrO, write1_odd, write1_pbit, write1_d128,
        output write_ins, write_data, busy
`ifdef DC1_XBIT_SCHED_STATS_EN
        , output stat_conflict, stat_ins
`endif
    );

endinterface

// File: rtl/dc1_xbit_wrsched_fifo.sv
// In-order update FIFO with occupancy count. The head entry is read directly
// from storage so an entry pushed at one edge is visible at the head next cycle.
module dc1_xbit_wrsched_fifo
    import dc1_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  xbit_upd_t                 pushData,
    input  logic                      pop,
    output logic                      headValid,
    output xbit_upd_t                 head,
    output logic [$clog2(FIFO_DEPTH):0] countNext
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    xbit_upd_t     mem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;
    logic          doPush, doPop;

    assign doPush    = push && (count < CW'(FIFO_DEPTH));
    assign doPop     = pop && headValid;
    assign headValid = (count != '0);
    assign head      = mem[rdPtr];
    assign countNext = count + CW'(doPush) - CW'(doPop);

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            count <= countNext;
        end
    end

    // Entry storage; occupancy alone defines validity, so data is never cleared.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/dc1_xbit_wrsched.sv
// dc1_xbit write scheduler: two update FIFOs feeding array ports 0/1 with
// same-row ordering via a round-robin pointer, plus a 4-state insert sequence
// that keeps both update ports idle around write_ins.
// Optional statistics counters: define DC1_XBIT_SCHED_STATS_EN.
module dc1_xbit_wrsched
    import dc1_pkg::*;
#(
    parameter int ADDR_WIDTH = XB_ROW_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    dc1_xbit_wrsched_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    xbit_upd_t       push0Data, push1Data, head0, head1;
    logic            head0Valid, head1Valid, push0, push1;
    logic [CW-1:0]   count0Next, count1Next;
    ins_state_t      state, stateNext;
    logic            rr, rrNext;
    logic            canIssue, conflict, issue0, issue1, insAccept;
    logic [1:0]              insBank_p0;
    logic [15:0]             insData_p0;
    logic [ADDR_WIDTH+4:0]   insAddrE_p0, insAddrO_p0;

    assign push0Data = '{addrE: bus.upd0_addrE, addrO: bus.upd0_addrO, odd: bus.upd0_odd,
                         pbit: bus.upd0_pbit, d128: bus.upd0_d128};
    assign push1Data = '{addrE: bus.upd1_addrE, addrO: bus.upd1_addrO, odd: bus.upd1_odd,
                         pbit: bus.upd1_pbit, d128: bus.upd1_d128};
    assign push0 = bus.upd0_valid && bus.upd0_ready;
    assign push1 = bus.upd1_valid && bus.upd1_ready;

    dc1_xbit_wrsched_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) fifo0 (
        .clk(clk), .rst(rst), .push(push0), .pushData(push0Data), .pop(issue0),
        .headValid(head0Valid), .head(head0), .countNext(count0Next)
    );

    dc1_xbit_wrsched_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) fifo1 (
        .clk(clk), .rst(rst), .push(push1), .pushData(push1Data), .pop(issue1),
        .headValid(head1Valid), .head(head1), .countNext(count1Next)
    );

    // Insert sequencing and the per-cycle update issue decision.
    always_comb begin
        stateNext = state;
        insAccept = 1'b0;
        canIssue  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ins_valid) begin
                    insAccept = 1'b1;
                    stateNext = DRAIN;
                end else begin
                    canIssue = 1'b1;
                end
            end
            DRAIN:   stateNext = ISSUE;
            ISSUE:   stateNext = HOLD;
            HOLD:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        conflict = head0Valid && head1Valid &&
                   ((rowKey(head0) == rowKey(head1)) || spansBank(head0) || spansBank(head1));
        issue0 = canIssue && head0Valid && (!conflict || !rr);
        issue1 = canIssue && head1Valid && (!conflict || rr);
        rrNext = rr ^ (canIssue && conflict);
    end

    // FSM state, round-robin pointer and captured insert payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            state <= stateNext;
            rr    <= rrNext;
        end
        if (insAccept) begin
            insBank_p0  <= bus.ins_bank;
            insData_p0  <= bus.ins_data;
            insAddrE_p0 <= bus.ins_addrE;
            insAddrO_p0 <= bus.ins_addrO;
        end
    end

    // Registered array drive; only clkEn/write_ins are qualified, other fields hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.upd0_ready   <= 1'b1;
            bus.upd1_ready   <= 1'b1;
            bus.ins_ready    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.write0_clkEn <= 1'b0;
            bus.write0_addrE <= '0;
            bus.write0_addrO <= '0;
            bus.write0_odd   <= 1'b0;
            bus.write0_pbit  <= '0;
            bus.write0_d128  <= 1'b0;
            bus.write1_clkEn <= 1'b0;
            bus.write1_addrE <= '0;
            bus.write1_addrO <= '0;
            bus.write1_odd   <= 1'b0;
            bus.write1_pbit  <= '0;
            bus.write1_d128  <= 1'b0;
            bus.write_ins    <= '0;
            bus.write_data   <= '0;
        end else begin
            bus.upd0_ready   <= count0Next < CW'(FIFO_DEPTH);
            bus.upd1_ready   <= count1Next < CW'(FIFO_DEPTH);
            bus.ins_ready    <= insAccept;
            bus.busy         <= (count0Next != '0) || (count1Next != '0) || (stateNext != IDLE);
            bus.write0_clkEn <= issue0;
            bus.write1_clkEn <= issue1;
            bus.write_ins    <= (state == ISSUE) ? insBank_p0 : 2'b00;
            if (issue0) begin
                bus.write0_addrE <= head0.addrE;
                bus.write0_addrO <= head0.addrO;
                bus.write0_odd   <= head0.odd;
                bus.write0_pbit  <= head0.pbit;
                bus.write0_d128  <= head0.d128;
            end
            if (state == ISSUE) begin
                bus.write0_addrE <= insAddrE_p0;
                bus.write0_addrO <= insAddrO_p0;
                bus.write_data   <= insData_p0;
            end
            if (issue1) begin
                bus.write1_addrE <= head1.addrE;
                bus.write1_addrO <= head1.addrO;
                bus.write1_odd   <= head1.odd;
                bus.write1_pbit  <= head1.pbit;
                bus.write1_d128  <= head1.d128;
            end
        end
    end

`ifdef DC1_XBIT_SCHED_STATS_EN
    // Saturating counts of conflict-stall cycles and accepted inserts.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stat_conflict <= '0;
            bus.stat_ins      <= '0;
        end else begin
            if (canIssue && conflict && (bus.stat_conflict != 16'hffff))
                bus.stat_conflict <= bus.stat_conflict + 16'd1;
            if (insAccept && (bus.stat_ins != 16'hffff))
                bus.stat_ins <= bus.stat_ins + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dc1_xbit_wrsched.sv
// Bench for dc1_xbit_wrsched: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model of the scheduler.
module tb_dc1_xbit_wrsched;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [9:0] addrE;
        logic [9:0] addrO;
        logic       odd;
        logic [1:0] pbit;
        logic       d128;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    dc1_xbit_wrsched_if #(.ADDR_WIDTH(5)) bus ();

    dc1_xbit_wrsched #(.ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state: pending updates per port, rr owner, insert progress.
    upd_t       q0[$], q1[$];
    bit         mRr;
    int         mPhase;
    logic [1:0] mBank;
    logic [15:0] mData;
    logic [9:0] mInsE, mInsO;
    // Expected outputs for the cycle after the next clock edge.
    logic       eRdy0, eRdy1, eInsRdy, eBusy, eW0En, eW1En;
    upd_t       eW0, eW1;
    logic [1:0] eWins;
    logic [15:0] eWdata;

    function automatic int rowOf(input upd_t u);
        int a;
        a = u.odd ? int'(u.addrO) : int'(u.addrE);
        return (u.odd ? 32 : 0) + (a / 16) % 32;
    endfunction

    function automatic bit spans(input upd_t u);
        int a;
        a = u.odd ? int'(u.addrO) : int'(u.addrE);
        return u.d128 && (a % 16 == 15);
    endfunction

    function automatic logic [9:0] randAddr();
        logic [1:0] row;
        logic [3:0] low;
        row = 2'($urandom);
        low = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom);
        return {4'b0000, row, low};
    endfunction

    task automatic modelStep();
        upd_t in0, in1;
        bit   acc0, acc1, go0, go1, conf;
        in0 = '{addrE: bus.upd0_addrE, addrO: bus.upd0_addrO, odd: bus.upd0_odd,
                pbit: bus.upd0_pbit, d128: bus.upd0_d128};
        in1 = '{addrE: bus.upd1_addrE, addrO: bus.upd1_addrO, odd: bus.upd1_odd,
                pbit: bus.upd1_pbit, d128: bus.upd1_d128};
        if (rst) begin
            q0.delete(); q1.delete();
            mRr = 0; mPhase = 0;
            eRdy0 = 1; eRdy1 = 1; eInsRdy = 0; eBusy = 0;
            eW0En = 0; eW1En = 0; eW0 = '0; eW1 = '0; eWins = 0; eWdata = 0;
        end else begin
            acc0 = bus.upd0_valid && (q0.size() < DEPTH);
            acc1 = bus.upd1_valid && (q1.size() < DEPTH);
            go0 = 0; go1 = 0; eInsRdy = 0; eWins = 0;
            if (mPhase == 0) begin
                if (bus.ins_valid) begin
                    eInsRdy = 1;
                    mBank = bus.ins_bank; mData = bus.ins_data;
                    mInsE = bus.ins_addrE; mInsO = bus.ins_addrO;
                    mPhase = 1;
                end else begin
                    conf = (q0.size() > 0) && (q1.size() > 0) &&
                           (rowOf(q0[0]) == rowOf(q1[0]) || spans(q0[0]) || spans(q1[0]));
                    go0 = (q0.size() > 0) && (!conf || !mRr);
                    go1 = (q1.size() > 0) && (!conf || mRr);
                    if (conf) mRr = !mRr;
                end
            end else if (mPhase == 2) begin
                eWins = mBank; eWdata = mData;
                eW0.addrE = mInsE; eW0.addrO = mInsO;
                mPhase = 3;
            end else begin
                mPhase = (mPhase + 1) % 4;
            end
            eW0En = go0; eW1En = go1;
            if (go0) eW0 = q0.pop_front();
            if (go1) eW1 = q1.pop_front();
            if (acc0) q0.push_back(in0);
            if (acc1) q1.push_back(in1);
            eRdy0 = q0.size() < DEPTH;
            eRdy1 = q1.size() < DEPTH;
            eBusy = (q0.size() != 0) || (q1.size() != 0) || (mPhase != 0);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        chk("upd_ready", {bus.upd0_ready, bus.upd1_ready}, {eRdy0, eRdy1});
        chk("ins_ready", bus.ins_ready, eInsRdy);
        chk("busy", bus.busy, eBusy);
        chk("port0", {bus.write0_clkEn, bus.write0_addrE, bus.write0_addrO, bus.write0_odd,
                      bus.write0_pbit, bus.write0_d128}, {eW0En, eW0});
        chk("port1", {bus.write1_clkEn, bus.write1_addrE, bus.write1_addrO, bus.write1_odd,
                      bus.write1_pbit, bus.write1_d128}, {eW1En, eW1});
        chk("insert", {bus.write_ins, bus.write_data}, {eWins, eWdata});
    endtask

    task automatic setUpd0(input logic v, input logic [9:0] aE, input logic [9:0] aO,
                           input logic od, input logic [1:0] pb, input logic d);
        bus.upd0_valid = v; bus.upd0_addrE = aE; bus.upd0_addrO = aO;
        bus.upd0_odd = od; bus.upd0_pbit = pb; bus.upd0_d128 = d;
    endtask

    task automatic setUpd1(input logic v, input logic [9:0] aE, input logic [9:0] aO,
                           input logic od, input logic [1:0] pb, input logic d);
        bus.upd1_valid = v; bus.upd1_addrE = aE; bus.upd1_addrO = aO;
        bus.upd1_odd = od; bus.upd1_pbit = pb; bus.upd1_d128 = d;
    endtask

    task automatic setIns(input logic v, input logic [1:0] bank, input logic [15:0] data,
                          input logic [9:0] aE, input logic [9:0] aO);
        bus.ins_valid = v; bus.ins_bank = bank; bus.ins_data = data;
        bus.ins_addrE = aE; bus.ins_addrO = aO;
    endtask

    task automatic clearInputs();
        bus.upd0_valid = 0;
        bus.upd1_valid = 0;
        bus.ins_valid  = 0;
    endtask

    initial begin
        setUpd0(0, 0, 0, 0, 0, 0);
        setUpd1(0, 0, 0, 0, 0, 0);
        setIns(0, 0, 0, 0, 0);

        // Reset state
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_ready0", bus.upd0_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_wins", bus.write_ins, 2'b00);

        // Single port-0 update: issues two cycles after enqueue
        setUpd0(1, 10'h015, 10'h000, 0, 2'b11, 0);
        tick();
        clearInputs();
        tick();
        chk("single_en0", bus.write0_clkEn, 1'b1);
        chk("single_addrE", bus.write0_addrE, 10'h015);
        chk("single_en1", bus.write1_clkEn, 1'b0);
        tick();

        // Same-row pair twice: rr alternates which port goes first
        for (int r = 0; r < 2; r++) begin
            setUpd0(1, 10'h000, 10'h123, 1, 2'b01, 0);
            setUpd1(1, 10'h000, 10'h12a, 1, 2'b10, 0);
            tick();
            clearInputs();
            tick();
            chk("row_first0", bus.write0_clkEn, (r == 0) ? 1'b1 : 1'b0);
            chk("row_first1", bus.write1_clkEn, (r == 0) ? 1'b0 : 1'b1);
            tick();
            chk("row_second0", bus.write0_clkEn, (r == 0) ? 1'b0 : 1'b1);
            chk("row_second1", bus.write1_clkEn, (r == 0) ? 1'b1 : 1'b0);
        end
        tick();

        // d128 at the end of a row spans banks and forces serialisation
        setUpd0(1, 10'h00f, 10'h000, 0, 2'b11, 1);
        setUpd1(1, 10'h000, 10'h200, 1, 2'b01, 0);
        tick();
        clearInputs();
        tick();
        chk("span_first", {bus.write0_clkEn, bus.write1_clkEn}, 2'b10);
        tick();
        chk("span_second", {bus.write0_clkEn, bus.write1_clkEn}, 2'b01);
        tick();

        // Insert while FIFO1 holds entries
        setUpd1(1, 10'h000, 10'h031, 1, 2'b01, 0);
        tick();
        setUpd1(1, 10'h000, 10'h042, 1, 2'b10, 0);
        setIns(1, 2'b01, 16'hA5A5, 10'h055, 10'h066);
        tick();
        clearInputs();
        chk("ins_T_ready", bus.ins_ready, 1'b1);
        tick();
        chk("ins_T1_w1", bus.write1_clkEn, 1'b0);
        tick();
        chk("ins_T2_wins", {bus.write_ins, bus.write_data}, {2'b01, 16'hA5A5});
        chk("ins_T2_w1", bus.write1_clkEn, 1'b0);
        tick();
        chk("ins_T3_w1", {bus.write1_clkEn, bus.write_ins}, 3'b000);
        tick();
        chk("ins_T4_resume", bus.write1_clkEn, 1'b1);
        tick(); tick();

        // FIFO0 fills while an insert blocks draining
        setIns(1, 2'b10, 16'h1234, 10'h077, 10'h088);
        for (int i = 0; i < 4; i++) begin
            setUpd0(1, 10'(16 * i + 1), 10'h000, 0, 2'(i), 0);
            tick();
            bus.ins_valid = 0;
        end
        chk("full_ready", bus.upd0_ready, 1'b0);
        setUpd0(1, 10'h0f1, 10'h000, 0, 2'b11, 0);
        tick();
        chk("full_reopen", bus.upd0_ready, 1'b1);
        tick();
        clearInputs();
        for (int i = 0; i < 6; i++) tick();

        // Reset with three entries queued and the FSM in DRAIN
        setUpd0(1, 10'h101, 10'h000, 0, 2'b01, 0);
        setUpd1(1, 10'h000, 10'h102, 1, 2'b10, 0);
        tick();
        setUpd0(1, 10'h113, 10'h000, 0, 2'b11, 0);
        bus.upd1_valid = 0;
        setIns(1, 2'b11, 16'hBEEF, 10'h0aa, 10'h0bb);
        tick();
        clearInputs();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ctrl", {bus.write0_clkEn, bus.write1_clkEn, bus.write_ins}, 4'b0000);
        for (int i = 0; i < 6; i++) tick();

        // Random traffic with occasional inserts and resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            setUpd0(1'($urandom_range(0, 1)), randAddr(), randAddr(), 1'($urandom_range(0, 1)),
                    2'($urandom), ($urandom_range(0, 3) == 0));
            setUpd1(1'($urandom_range(0, 1)), randAddr(), randAddr(), 1'($urandom_range(0, 1)),
                    2'($urandom), ($urandom_range(0, 3) == 0));
            setIns(($urandom_range(0, 15) == 0), 2'($urandom), 16'($urandom), randAddr(), randAddr());
            tick();
        end
        rst = 0;
        clearInputs();
        for (int i = 0; i < 10; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
